// File: rtl/led_sequencer.sv
// Round-robin LED blink-pattern sequencer: one requester at a time owns the shared LED.
// Define LED_HEARTBEAT_EN to make led_1 toggle every HB_TICKS ticks while idle.
module led_sequencer #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned HB_TICKS = 128
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] on_ticks,
  input  logic [8*NUM_REQ-1:0] off_ticks,
  input  logic [4*NUM_REQ-1:0] reps,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 led_1
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = $clog2(TICK_DIV);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TICK_DIV < 2 || HB_TICKS < 1) begin : g_bad_param
    $error("led_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               led_nxt;
  logic [IW-1:0]      ptr, ptr_nxt, win, win_nxt, pick, idx;
  logic               pick_ok;
  logic [7:0]         on_r, on_nxt, off_r, off_nxt, ticks, ticks_nxt;
  logic [3:0]         reps_r, reps_nxt, blinks, blinks_nxt;
  logic [PW-1:0]      presc, presc_nxt;
  logic               tick, go_idle;

  logic [7:0] on_arr   [NUM_REQ];
  logic [7:0] off_arr  [NUM_REQ];
  logic [3:0] reps_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign on_arr[g]   = on_ticks[8*g +: 8];
    assign off_arr[g]  = off_ticks[8*g +: 8];
    assign reps_arr[g] = reps[4*g +: 4];
  end

`ifdef LED_HEARTBEAT_EN
  localparam int unsigned HW = (HB_TICKS > 2) ? $clog2(HB_TICKS) : 1;
  logic [HW-1:0] hb_cnt, hb_nxt;
`endif

  // First requesting index at or after the pointer, wrapping.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(ptr) + k) % NUM_REQ);
      if (!pick_ok && req[idx]) begin
        pick_ok = 1'b1;
        pick    = idx;
      end
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    led_nxt    = led_1;
    ptr_nxt    = ptr;
    win_nxt    = win;
    on_nxt     = on_r;
    off_nxt    = off_r;
    reps_nxt   = reps_r;
    blinks_nxt = blinks;
    ticks_nxt  = ticks;
    presc_nxt  = tick ? '0 : presc + 1'b1;
    go_idle    = 1'b0;
`ifdef LED_HEARTBEAT_EN
    hb_nxt     = hb_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt  = ON;
          win_nxt    = pick;
          gnt_nxt    = NUM_REQ'(1) << pick;
          on_nxt     = (on_arr[pick] == '0) ? 8'd1 : on_arr[pick];
          off_nxt    = (off_arr[pick] == '0) ? 8'd1 : off_arr[pick];
          reps_nxt   = (reps_arr[pick] == '0) ? 4'd1 : reps_arr[pick];
          blinks_nxt = '0;
          ticks_nxt  = '0;
          presc_nxt  = '0;
          led_nxt    = 1'b1;
        end else begin
`ifdef LED_HEARTBEAT_EN
          if (tick) begin
            if (hb_cnt == HW'(HB_TICKS - 1)) begin
              hb_nxt  = '0;
              led_nxt = !led_1;
            end else begin
              hb_nxt = hb_cnt + 1'b1;
            end
          end
`else
          presc_nxt = '0;
`endif
        end
      end
      ON: begin
        if (!req[win]) begin
          go_idle = 1'b1;
        end else if (tick) begin
          if (ticks == on_r - 8'd1) begin
            ticks_nxt = '0;
            led_nxt   = 1'b0;
            state_nxt = OFF;
          end else begin
            ticks_nxt = ticks + 8'd1;
          end
        end
      end
      OFF: begin
        if (!req[win]) begin
          go_idle = 1'b1;
        end else if (tick) begin
          if (ticks == off_r - 8'd1) begin
            ticks_nxt = '0;
            if ({1'b0, blinks} + 5'd1 < {1'b0, reps_r}) begin
              blinks_nxt = blinks + 4'd1;
              led_nxt    = 1'b1;
              state_nxt  = ON;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            ticks_nxt = ticks + 8'd1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
    // Completion and abort share the exit path; pointer moves past the winner either way.
    if (go_idle) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      led_nxt   = 1'b0;
      presc_nxt = '0;
      ticks_nxt = '0;
      ptr_nxt   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef LED_HEARTBEAT_EN
      hb_nxt    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      gnt    <= '0;
      led_1  <= 1'b0;
      ptr    <= '0;
      win    <= '0;
      on_r   <= '0;
      off_r  <= '0;
      reps_r <= '0;
      blinks <= '0;
      ticks  <= '0;
      presc  <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      led_1  <= led_nxt;
      ptr    <= ptr_nxt;
      win    <= win_nxt;
      on_r   <= on_nxt;
      off_r  <= off_nxt;
      reps_r <= reps_nxt;
      blinks <= blinks_nxt;
      ticks  <= ticks_nxt;
      presc  <= presc_nxt;
    end
  end

`ifdef LED_HEARTBEAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hb_cnt <= '0;
    else         hb_cnt <= hb_nxt;
  end
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: elapsed-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_led_sequencer;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int HB  = 2;

  logic        clk, resetn;
  logic [3:0]  req;
  logic [31:0] on_ticks, off_ticks;
  logic [15:0] reps;
  logic [3:0]  gnt;
  logic        busy, done, led_1;

  int total, bad;

  // Model: mode 0 idle, 1 pattern running, 2 completion cycle.
  int m_mode, m_ptr, m_win, m_t, m_on, m_off, m_reps, m_idle;

  led_sequencer #(.NUM_REQ(N), .TICK_DIV(DIV), .HB_TICKS(HB)) dut (
    .clk(clk), .resetn(resetn), .req(req), .on_ticks(on_ticks), .off_ticks(off_ticks),
    .reps(reps), .gnt(gnt), .busy(busy), .done(done), .led_1(led_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int field(input logic [31:0] v, input int lsb, input int w);
    return int'((v >> lsb) & ((32'd1 << w) - 32'd1));
  endfunction

  function automatic int at_least_one(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic hb_level(input int idle_cycles);
`ifdef LED_HEARTBEAT_EN
    return ((idle_cycles / (HB * DIV)) % 2) == 1;
`else
    return (idle_cycles < 0);
`endif
  endfunction

  task automatic model_step();
    bit found;
    if (!resetn) begin
      m_mode = 0; m_ptr = 0; m_idle = 0; m_t = 0;
      return;
    end
    case (m_mode)
      1: begin
        if (field(32'(req), m_win, 1) == 0) begin
          m_mode = 0; m_ptr = (m_win + 1) % N; m_idle = 0;
        end else begin
          m_t++;
          if (m_t == m_reps * (m_on + m_off) * DIV) m_mode = 2;
        end
      end
      2: begin
        m_mode = 0; m_ptr = (m_win + 1) % N; m_idle = 0;
      end
      default: begin
        if (req != 4'b0) begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && field(32'(req), (m_ptr + k) % N, 1) == 1) begin
              found = 1'b1;
              m_win = (m_ptr + k) % N;
            end
          end
          m_on   = at_least_one(field(on_ticks, 8 * m_win, 8));
          m_off  = at_least_one(field(off_ticks, 8 * m_win, 8));
          m_reps = at_least_one(field(32'(reps), 4 * m_win, 4));
          m_t    = 0;
          m_mode = 1;
        end else begin
          m_idle++;
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [3:0] eg;
    logic eb, ed, el;
    eg = '0; eb = 1'b0; ed = 1'b0; el = 1'b0;
    if (m_mode != 0) begin
      eg = 4'(1 << m_win);
      eb = 1'b1;
    end
    if (m_mode == 2) ed = 1'b1;
    if (m_mode == 1) el = ((m_t % ((m_on + m_off) * DIV)) < m_on * DIV);
    else if (m_mode == 0) el = hb_level(m_idle);
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(eb));
    check("done", 32'(done), 32'(ed));
    check("led_1", 32'(led_1), 32'(el));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_cfg(input int i, input int on, input int off, input int rp);
    on_ticks  = (on_ticks & ~(32'hFF << (8 * i))) | (32'(on) << (8 * i));
    off_ticks = (off_ticks & ~(32'hFF << (8 * i))) | (32'(off) << (8 * i));
    reps      = (reps & ~(16'hF << (4 * i))) | (16'(rp) << (4 * i));
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  // Grants on the first step, then records led_1 (MSB-first) until done appears.
  task automatic run_pattern(input int bound, input bit scramble, output logic [31:0] seq,
                             output int done_at, output int ndone, output logic [3:0] first_gnt);
    seq = '0; done_at = -1; ndone = 0;
    step();
    first_gnt = gnt;
    if (scramble) begin
      on_ticks = '1; off_ticks = '1; reps = '1;
    end
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = i;
          req = '0;
        end
      end else if (done_at < 0) begin
        seq = {seq[30:0], led_1};
      end
      if (done_at >= 0 && i >= done_at + 3) break;
      step();
    end
  endtask

  function automatic int oh_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    logic [31:0] seq;
    logic [3:0]  g0;
    int done_at, ndone, ngr, order, idle_run, gap_err, nb, done_seen, reached;
    logic pb, pl;

    total = 0; bad = 0;
    m_mode = 0; m_ptr = 0; m_win = 0; m_t = 0; m_on = 1; m_off = 1; m_reps = 1; m_idle = 0;
    resetn = 1'b0; req = '0; on_ticks = '0; off_ticks = '0; reps = '0;
    step();
    step();
    check("rst_outs", {25'd0, gnt, busy, done, led_1}, 32'd0);
    resetn = 1'b1;

    // Single requester, two blinks of 2 ticks on / 1 tick off.
    set_cfg(1, 2, 1, 2);
    req = 4'b0010;
    run_pattern(60, 1'b0, seq, done_at, ndone, g0);
    check("blink_gnt", 32'(g0), 32'h2);
    check("blink_seq", seq, 32'h00FF0FF0);
    check("blink_done_at", 32'(done_at), 32'd24);
    check("blink_done_cnt", 32'(ndone), 32'd1);

    // All requesting: round-robin from index 0 with one idle cycle between patterns.
    reset_pulse();
    for (int i = 0; i < N; i++) set_cfg(i, 1, 1, 1);
    req = 4'b1111;
    ngr = 0; order = 0; idle_run = 0; gap_err = 0; pb = busy;
    for (int c = 0; c < 200 && ngr < 5; c++) begin
      step();
      if (busy && !pb) begin
        if (ngr > 0 && idle_run != 1) gap_err++;
        order = (order << 4) | oh_idx(gnt);
        ngr++;
        idle_run = 0;
      end else if (!busy) begin
        idle_run++;
      end
      pb = busy;
    end
    check("rr_count", 32'(ngr), 32'd5);
    check("rr_order", 32'(order), 32'h00001230);
    check("rr_gaps", 32'(gap_err), 32'd0);
    req = '0;
    step();
    step();

    // Abort during the second blink's ON phase.
    set_cfg(2, 2, 2, 3);
    req = 4'b0100;
    nb = 0; done_seen = 0; pb = busy; pl = led_1;
    for (int c = 0; c < 100 && nb < 2; c++) begin
      step();
      if (busy && led_1 && !(pb && pl)) nb++;
      if (done) done_seen++;
      pb = busy; pl = led_1;
    end
    check("abort_reach", 32'(nb), 32'd2);
    step();
    step();
    req = '0;
    step();
    check("abort_outs", {25'd0, gnt, busy, done, led_1}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Zero parameters act as one; later input changes do not disturb the pattern.
    set_cfg(0, 0, 0, 0);
    req = 4'b0001;
    run_pattern(40, 1'b1, seq, done_at, ndone, g0);
    check("zero_gnt", 32'(g0), 32'h1);
    check("zero_seq", seq, 32'h000000F0);
    check("zero_done_at", 32'(done_at), 32'd8);
    check("zero_done_cnt", 32'(ndone), 32'd1);

    // Asynchronous reset in the OFF phase, then a fresh grant.
    on_ticks = '0; off_ticks = '0; reps = '0;
    set_cfg(0, 1, 2, 1);
    req = 4'b0001;
    reached = 0;
    for (int c = 0; c < 50 && reached == 0; c++) begin
      step();
      if (busy && !led_1) reached = 1;
    end
    check("rst_reach_off", 32'(reached), 32'd1);
    step();
    #2 resetn = 1'b0;
    #1 check("rst_async", {25'd0, gnt, busy, done, led_1}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    set_cfg(3, 1, 1, 1);
    req = 4'b1000;
    step();
    check("rst_regrant", 32'(gnt), 32'h8);
    req = '0;
    step();
    step();

    // Idle LED behaviour with no requests.
    reset_pulse();
    seq = '0;
    for (int c = 0; c < 24; c++) begin
      step();
      seq = {seq[30:0], led_1};
    end
`ifdef LED_HEARTBEAT_EN
    check("idle_led", seq, 32'h0001FE01);
`else
    check("idle_led", seq, 32'h00000000);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 599) == 0) resetn = 1'b0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 59) == 0) req = req ^ 4'(1 << b);
      if ($urandom_range(0, 15) == 0) begin
        on_ticks  = $urandom & 32'h03030303;
        off_ticks = $urandom & 32'h03030303;
        reps      = 16'($urandom) & 16'h3333;
      end
      step();
    end
    resetn = 1'b1;
    req = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
